wb_regfile_pipe: RTL
====================

Name: wb_regfile_pipe

Overview:
Writeback-stage consumer of the W pipeline register. Takes the retiring instruction's W_* fields, commits valE/valM into the 15-entry Y86-64 register file, and serves the decode stage's two combinational read ports with same-cycle write-through bypass. Owns the architectural status: a RUN/HALTED state machine and a retired-instruction counter.

Parameters:
NREGS, 15, architectural registers (IDs 0x0-0xE); ID 0xF = RNONE, never written
DW, 64, data width
CW, 64, retired-instruction counter width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
W_stat  in  3  status of the retiring instruction: BUB=0, AOK=1, HLT=2, ADR=3, INS=4
W_icode  in  4  icode of the retiring instruction (NOP=1, HALT=0)
W_valE  in  64  ALU result
W_valM  in  64  memory read data
W_dstE  in  4  destination register for valE (0xF = none)
W_dstM  in  4  destination register for valM (0xF = none)
d_srcA  in  4  decode read port A ID
d_srcB  in  4  decode read port B ID
d_rvalA  out  64  read data A (combinational)
d_rvalB  out  64  read data B (combinational)
stat  out  3  architectural status, registered
halted  out  1  high in HALTED state
retired  out  64  count of committed instructions

Behaviour:
- Reset (async, immediate): all 15 registers = 0, state RUN, stat = AOK, halted = 0, retired = 0. Reset mid-operation discards any in-flight write and any pending halt.
- Commit enable: wen = (state==RUN) and (W_stat==AOK). Bubbles (W_stat==BUB) and HLT/ADR/INS cycles never write.
- Write E: if wen and W_dstE != 0xF, reg[W_dstE] <= W_valE on posedge.
- Write M: if wen and W_dstM != 0xF, reg[W_dstM] <= W_valM.
- W_dstE == W_dstM != 0xF (e.g. popq %rsp): valM wins; valE is discarded.
- Read ports: src == 0xF -> 0. Otherwise, if wen and src == W_dstM -> W_valM; else if wen and src == W_dstE -> W_valE; else reg[src]. Bypass priority mirrors write priority. Both ports independent; srcA == srcB is legal.
- Reads in HALTED return stored register contents (no bypass, since wen = 0).
- FSM: RUN -> HALTED on posedge when W_stat in {HLT, ADR, INS}; stat <= W_stat on that edge. HALTED is absorbing until rst; W_* ignored thereafter, stat and registers frozen.
- W_stat values 5-7: treated as INS (stat <= 4, enter HALTED).
- In RUN with W_stat in {BUB, AOK}: stat stays AOK.
- retired: +1 on posedge when wen and W_icode != NOP; +1 also on the edge entering HALTED with W_stat==HLT (the halt instruction retires); ADR/INS do not count. Wraps modulo 2^CW.
- Latency: write visible in reg array one edge after presentation; visible on read ports in the same cycle via bypass.

Decomposition:
- Shared package y86_pkg: stat codes (STAT_BUB/AOK/HLT/ADR/INS), icode constants (I_HALT, I_NOP, ...), RNONE = 4'hF, register ID names (RSP = 4'h4, ...), fsm state enum.
- One sub-module natural: rf_bank_2w2r (15x64 storage, two write ports with M-priority, two async read ports, async reset); the parent holds the FSM, commit gating, bypass and counter.

Test Plan:
- Reset then W_stat=AOK, W_icode=irmovq, W_dstE=0x2, W_valE=0x1234, d_srcA=0x2 -> d_rvalA=0x1234 same cycle (bypass); next cycle reg2=0x1234, retired=1.
- popq %rsp: W_dstE=0x4 valE=0x100, W_dstM=0x4 valM=0xBEEF -> reg4=0xBEEF; d_srcB=0x4 during the cycle reads 0xBEEF.
- W_stat=BUB, W_icode=NOP, W_dstE=0x3, valE=0xFF -> reg3 unchanged, retired unchanged, stat=AOK.
- W_stat=ADR with W_dstM=0x5, valM=0x77 -> reg5 unchanged, stat=3, halted=1, retired unchanged; subsequent AOK writes to reg5 ignored.
- W_stat=HLT, W_icode=HALT -> stat=2, halted=1, retired +1; reads of d_srcA=0xF return 0.
- Assert rst asynchronously mid-cycle while HALTED with reg2=0x1234 -> immediately stat=AOK, halted=0, retired=0, d_rvalA for src 0x2 = 0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: status codes, icodes, register IDs and the
// writeback-stage state encoding.
package y86_pkg;

  typedef enum logic [2:0] {
    STAT_BUB = 3'd0,
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } wb_state_e;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RAX   = 4'h0;
  localparam logic [3:0] RCX   = 4'h1;
  localparam logic [3:0] RDX   = 4'h2;
  localparam logic [3:0] RBX   = 4'h3;
  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RBP   = 4'h5;
  localparam logic [3:0] RSI   = 4'h6;
  localparam logic [3:0] RDI   = 4'h7;
  localparam logic [3:0] R14   = 4'hE;
  localparam logic [3:0] RNONE = 4'hF;

  // Any status outside the defined fault codes is architecturally an INS fault.
  function automatic stat_e fault_stat(input logic [2:0] s);
    case (s)
      STAT_HLT: fault_stat = STAT_HLT;
      STAT_ADR: fault_stat = STAT_ADR;
      default:  fault_stat = STAT_INS;
    endcase
  endfunction

endpackage

// File: rtl/rf_bank_2w2r.sv
// Register storage with two write ports (M beats E on a shared target) and
// two asynchronous read ports; IDs at or above NREGS read as zero.
module rf_bank_2w2r
  import y86_pkg::*;
#(
  parameter int NREGS = 15,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_e,
  input  logic [3:0]    addr_e,
  input  logic [DW-1:0] data_e,
  input  logic          we_m,
  input  logic [3:0]    addr_m,
  input  logic [DW-1:0] data_m,
  input  logic [3:0]    raddr_a,
  input  logic [3:0]    raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] regs [NREGS];

  // NOTE: the array is cleared on reset because the architecture defines all
  // registers as zero after reset; that forces flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (we_m && addr_m == 4'(i))      regs[i] <= data_m;
        else if (we_e && addr_e == 4'(i)) regs[i] <= data_e;
      end
    end
  end

  // NOTE: outputs get a default before the loop so no latch is inferred.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (raddr_a == 4'(i)) rdata_a = regs[i];
      if (raddr_b == 4'(i)) rdata_b = regs[i];
    end
  end

endmodule

// File: rtl/wb_regfile_pipe.sv
// Writeback stage: commits W-register results into the register file, bypasses
// them to decode reads, and owns architectural status and retire count.
module wb_regfile_pipe
  import y86_pkg::*;
#(
  parameter int NREGS = 15,
  parameter int DW    = 64,
  parameter int CW    = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    W_stat,
  input  logic [3:0]    W_icode,
  input  logic [DW-1:0] W_valE,
  input  logic [DW-1:0] W_valM,
  input  logic [3:0]    W_dstE,
  input  logic [3:0]    W_dstM,
  input  logic [3:0]    d_srcA,
  input  logic [3:0]    d_srcB,
  output logic [DW-1:0] d_rvalA,
  output logic [DW-1:0] d_rvalB,
  output logic [2:0]    stat,
  output logic          halted,
  output logic [CW-1:0] retired
);

  wb_state_e     state_q, state_d;
  stat_e         stat_q, stat_d;
  logic [CW-1:0] retired_q;
  logic          wen, retire_inc;
  logic [DW-1:0] bank_a, bank_b;

  assign wen = (state_q == ST_RUN) && (W_stat == STAT_AOK);

  // A HLT retires as it halts; ADR/INS faults never count.
  assign retire_inc = (wen && W_icode != I_NOP) ||
                      (state_q == ST_RUN && W_stat == STAT_HLT);

  rf_bank_2w2r #(.NREGS(NREGS), .DW(DW)) u_bank (
    .clk     (clk),
    .rst     (rst),
    .we_e    (wen && W_dstE != RNONE),
    .addr_e  (W_dstE),
    .data_e  (W_valE),
    .we_m    (wen && W_dstM != RNONE),
    .addr_m  (W_dstM),
    .data_m  (W_valM),
    .raddr_a (d_srcA),
    .raddr_b (d_srcB),
    .rdata_a (bank_a),
    .rdata_b (bank_b)
  );

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    if (state_q == ST_RUN) begin
      if (W_stat == STAT_BUB || W_stat == STAT_AOK) begin
        stat_d = STAT_AOK;
      end else begin
        state_d = ST_HALTED;
        stat_d  = fault_stat(W_stat);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      stat_q    <= STAT_AOK;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      if (retire_inc) retired_q <= retired_q + CW'(1);
    end
  end

  // Bypass priority mirrors the write priority: valM over valE.
  function automatic logic [DW-1:0] bypass(input logic [3:0]    src,
                                           input logic [DW-1:0] stored);
    if (src == RNONE)                  bypass = '0;
    else if (wen && src == W_dstM)     bypass = W_valM;
    else if (wen && src == W_dstE)     bypass = W_valE;
    else                               bypass = stored;
  endfunction

  always_comb begin
    d_rvalA = bypass(d_srcA, bank_a);
    d_rvalB = bypass(d_srcB, bank_b);
  end

  assign stat    = stat_q;
  assign halted  = (state_q == ST_HALTED);
  assign retired = retired_q;

endmodule
